spi_to_axi_master: RTL and testbench
====================================

Name: spi_to_axi_master

Overview:
- SPI slave (mode 0, MSB first) that turns serial command frames from an external host into AXI-Lite master read/write transactions.
- Sits in front of any AXI-Lite slave in the design, including the existing AXI-Lite SPI peripheral, so an off-chip controller can access the register map.
- SPI pins are oversampled in the ACLK domain. There is no separate SCK clock domain.

Parameters:
- BASE_ADDR, 32'h0000_0000, added to the word address from the command byte.
- SYNC_STAGES, 2, synchronizer depth on SPI_SCK, SPI_CS and SPI_MOSI (minimum 2).
- TIMEOUT, 255, ACLK cycles to wait for an AXI handshake before the transaction is flagged as an error.

Ports:
- ACLK  in  1  system clock; must be ≥ 8× SPI_SCK (16 MHz ACLK, ≤ 2 MHz SCK).
- ARESET  in  1  asynchronous, active-high reset.
- SPI_SCK  in  1  host serial clock, idle low.
- SPI_CS  in  1  chip select, active low.
- SPI_MOSI  in  1  host-to-slave data.
- SPI_MISO  out  1  slave-to-host data.
- AWVALID  out  1  write address valid.
- AWREADY  in  1  write address ready.
- AWADDR  out  32  write address.
- WVALID  out  1  write data valid.
- WREADY  in  1  write data ready.
- WDATA  out  32  write data.
- ARVALID  out  1  read address valid.
- ARREADY  in  1  read address ready.
- ARADDR  out  32  read address.
- RVALID  in  1  read data valid.
- RREADY  out  1  read data ready.
- RDATA  in  32  read data.
- BUSY  out  1  high from CS falling edge until the frame and its AXI transaction are complete.
- ERR  out  1  sticky error flag; cleared by a command byte of 8'h7F.

Behaviour:
- Reset values (async on ARESET): all VALIDs 0, RREADY 0, AWADDR/ARADDR/WDATA 0, SPI_MISO 0, BUSY 0, ERR 0, FSM in IDLE.
- Input conditioning: SCK, CS and MOSI pass through SYNC_STAGES flops. Edge detect is done on synchronized SCK:
  - rise: sample MOSI into the shift register.
  - fall: shift MISO out.
- Frame format:
  - Byte 0 is the command: bit7 = 1 read / 0 write; bits6:0 = word index. Address = BASE_ADDR + {index, 2'b00}.
  - Write frame: command + 4 data bytes (40 bits, MSB first).
  - Read frame: command + 1 dummy byte + 4 data bytes (48 bits). MISO carries RDATA MSB first during the data bytes and 0 during the command and dummy bytes.
- FSM states and transitions:
  - IDLE → CMD on CS falling edge; bit counter cleared.
  - CMD: after the 8th rising edge, go to WR_DATA (bit7 = 0) or RD_REQ (bit7 = 1).
  - WR_DATA: after 32 more bits, latch WDATA and go to WR_ISSUE.
  - WR_ISSUE:
    - AWVALID and WVALID assert in the same cycle.
    - Each channel drops independently on its own VALID&READY cycle.
    - Go to DONE when both channels have handshaken.
  - RD_REQ: ARVALID held until ARREADY, then RREADY = 1 until RVALID. On RVALID, RDATA is captured into the MISO shift register; go to RD_SHIFT.
  - RD_SHIFT: on the first SCK fall after the dummy byte, drive bit31, then shift once per fall. Go to DONE after 32 bits.
  - DONE → IDLE when CS returns high. Further SCK activity in DONE is ignored and MISO is 0.
- Read latency budget: RVALID must arrive before the end of the dummy byte. Otherwise ERR is set and 32'h0 is shifted out; the AXI read still completes and its data is discarded.
- Timeout: if a VALID is held for TIMEOUT cycles without READY, set ERR.
  - VALID is never dropped before its handshake (AXI rule). BUSY stays high until the handshake.
- CS deasserted mid-frame:
  - Before a write frame reaches 40 bits: frame discarded, no AXI write issued, ERR set.
  - After an AXI transaction has started: the transaction runs to completion, then the FSM goes to IDLE.
- CS falling while BUSY (previous AXI still pending): the new frame is ignored until IDLE, and ERR is set.
- Command 8'h7F with a write bit: clears ERR; no AXI access, remaining bits are ignored.
- Address arithmetic is 32-bit and wraps modulo 2^32.

Decomposition:
- Shared package spi_axi_pkg:
  - FSM state encoding (IDLE, CMD, WR_DATA, WR_ISSUE, RD_REQ, RD_SHIFT, DONE).
  - Frame length constants CMD_BITS = 8, DUMMY_BITS = 8, DATA_BITS = 32.
  - ERR_CLEAR_CMD = 8'h7F.
- One sub-module, spi_pin_sync: synchronizer plus SCK rise/fall edge detector. It outputs sck_rise, sck_fall, cs_n_s and mosi_s.

Test Plan:
- Write frame 8'h05 + 32'hA5A5_1234, BASE_ADDR = 32'h4000_0000, AWREADY/WREADY tied 1 → one AW and one W handshake with AWADDR = 32'h4000_0014 and WDATA = 32'hA5A5_1234; ERR = 0.
- Read frame 8'h83 + dummy byte, slave returns RVALID 3 cycles after ARREADY with RDATA = 32'hDEAD_BEEF → ARADDR = 32'h4000_000C; MISO data bytes read DE AD BE EF.
- WREADY delayed 10 cycles, AWREADY immediate → AWVALID drops after 1 cycle, WVALID is held 10 cycles; BUSY stays high until the W handshake.
- CS raised after 20 bits of a write frame → no AWVALID/WVALID ever asserted; ERR = 1. A following 8'h7F frame → ERR = 0.
- Read where RVALID arrives after the dummy byte ends → MISO shifts 32'h0; ERR = 1; RREADY/RVALID handshake still occurs.
- ARESET asserted during WR_ISSUE → all outputs return to their reset values immediately; the next write frame completes normally.

Source files
------------

// File: rtl/spi_axi_pkg.sv
// spi_axi_pkg: shared FSM encoding, SPI frame lengths and address helper for the SPI-to-AXI-Lite bridge
package spi_axi_pkg;
  typedef enum logic [2:0] {IDLE, CMD, WR_DATA, WR_ISSUE, RD_REQ, RD_SHIFT, DONE} state_t;
  localparam int CMD_BITS = 8;
  localparam int DUMMY_BITS = 8;
  localparam int DATA_BITS = 32;
  localparam logic [7:0] ERR_CLEAR_CMD = 8'h7F;
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [6:0] idx);
    return base + {23'd0, idx, 2'b00};
  endfunction
endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: synchronizes SCK/CS_n/MOSI into clk domain and flags SCK rise/fall (i_clk/i_rst, i_sck/i_cs_n/i_mosi -> o_sck_rise/o_sck_fall/o_cs_n_s/o_mosi_s)
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sck,
  input  logic i_cs_n,
  input  logic i_mosi,
  output logic o_sck_rise,
  output logic o_sck_fall,
  output logic o_cs_n_s,
  output logic o_mosi_s
);
  logic [SYNC_STAGES-1:0] r_sck, r_cs_n, r_mosi;
  logic r_sck_d;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sck   <= '0;
      r_cs_n  <= '1;
      r_mosi  <= '0;
      r_sck_d <= 1'b0;
    end else begin
      r_sck   <= {r_sck[SYNC_STAGES-2:0], i_sck};
      r_cs_n  <= {r_cs_n[SYNC_STAGES-2:0], i_cs_n};
      r_mosi  <= {r_mosi[SYNC_STAGES-2:0], i_mosi};
      r_sck_d <= r_sck[SYNC_STAGES-1];
    end
  end
  assign o_sck_rise = r_sck[SYNC_STAGES-1] & ~r_sck_d;
  assign o_sck_fall = ~r_sck[SYNC_STAGES-1] & r_sck_d;
  assign o_cs_n_s   = r_cs_n[SYNC_STAGES-1];
  assign o_mosi_s   = r_mosi[SYNC_STAGES-1];
endmodule

// File: rtl/spi_to_axi_master.sv
// spi_to_axi_master: mode-0 SPI slave (ACLK-oversampled pins) issuing AXI-Lite reads/writes; BUSY/ERR status outputs
module spi_to_axi_master
  import spi_axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          SYNC_STAGES = 2,
  parameter int          TIMEOUT     = 255
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        SPI_SCK,
  input  logic        SPI_CS,
  input  logic        SPI_MOSI,
  output logic        SPI_MISO,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] AWADDR,
  output logic        WVALID,
  input  logic        WREADY,
  output logic [31:0] WDATA,
  output logic        ARVALID,
  input  logic        ARREADY,
  output logic [31:0] ARADDR,
  input  logic        RVALID,
  output logic        RREADY,
  input  logic [31:0] RDATA,
  output logic        BUSY,
  output logic        ERR
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [5:0] CMD_LAST   = 6'(CMD_BITS - 1);
  localparam logic [5:0] WR_LAST    = 6'(CMD_BITS + DATA_BITS - 1);
  localparam logic [5:0] DATA_START = 6'(CMD_BITS + DUMMY_BITS);
  localparam logic [5:0] RD_END     = 6'(CMD_BITS + DUMMY_BITS + DATA_BITS);
  logic w_sck_rise, w_sck_fall, w_cs_n, w_mosi, w_cs_fall, w_axi_wait, w_late;
  logic [31:0] w_word;
  state_t r_state;
  logic r_cs_d, r_abort;
  logic [5:0] r_bit_cnt;
  logic [31:0] r_sr, r_miso_sr;
  logic [TW-1:0] r_to_cnt;
  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk(ACLK), .i_rst(ARESET), .i_sck(SPI_SCK), .i_cs_n(SPI_CS), .i_mosi(SPI_MOSI),
    .o_sck_rise(w_sck_rise), .o_sck_fall(w_sck_fall), .o_cs_n_s(w_cs_n), .o_mosi_s(w_mosi)
  );
  assign w_word     = {r_sr[30:0], w_mosi};
  assign w_cs_fall  = r_cs_d & ~w_cs_n;
  assign w_axi_wait = (r_state == WR_ISSUE) || (r_state == RD_REQ);
  // read data that misses the end of the dummy byte cannot be shifted out in time
  assign w_late     = r_bit_cnt >= DATA_START;
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state   <= IDLE;
      r_cs_d    <= 1'b1;
      r_abort   <= 1'b0;
      r_bit_cnt <= '0;
      r_sr      <= '0;
      r_miso_sr <= '0;
      r_to_cnt  <= '0;
      SPI_MISO  <= 1'b0;
      AWVALID   <= 1'b0;
      AWADDR    <= '0;
      WVALID    <= 1'b0;
      WDATA     <= '0;
      ARVALID   <= 1'b0;
      ARADDR    <= '0;
      RREADY    <= 1'b0;
      BUSY      <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      r_cs_d <= w_cs_n;
      if (w_sck_rise && !w_cs_n) begin
        r_sr <= w_word;
        if (r_bit_cnt != '1) r_bit_cnt <= r_bit_cnt + 6'd1;
      end
      if (!w_axi_wait) r_to_cnt <= '0;
      else if (r_to_cnt != TW'(TIMEOUT)) r_to_cnt <= r_to_cnt + 1'b1;
      if (r_to_cnt == TW'(TIMEOUT)) ERR <= 1'b1;
      // host started a new frame while the previous one is still in flight
      if (w_cs_fall && r_state != IDLE) ERR <= 1'b1;
      if (w_cs_n && r_state != IDLE) r_abort <= 1'b1;
      if (r_state != RD_SHIFT) SPI_MISO <= 1'b0;
      case (r_state)
        IDLE: if (w_cs_fall) begin
          r_state   <= CMD;
          BUSY      <= 1'b1;
          r_bit_cnt <= '0;
          r_abort   <= 1'b0;
        end
        CMD: if (w_cs_n) begin
          ERR     <= 1'b1;
          BUSY    <= 1'b0;
          r_state <= IDLE;
        end else if (w_sck_rise && r_bit_cnt == CMD_LAST) begin
          if (w_word[7:0] == ERR_CLEAR_CMD) begin
            ERR     <= 1'b0;
            r_state <= DONE;
          end else if (w_word[7]) begin
            ARADDR  <= word_addr(BASE_ADDR, w_word[6:0]);
            ARVALID <= 1'b1;
            r_state <= RD_REQ;
          end else begin
            AWADDR  <= word_addr(BASE_ADDR, w_word[6:0]);
            r_state <= WR_DATA;
          end
        end
        WR_DATA: if (w_cs_n) begin
          ERR     <= 1'b1;
          BUSY    <= 1'b0;
          r_state <= IDLE;
        end else if (w_sck_rise && r_bit_cnt == WR_LAST) begin
          WDATA   <= w_word;
          AWVALID <= 1'b1;
          WVALID  <= 1'b1;
          r_state <= WR_ISSUE;
        end
        WR_ISSUE: begin
          if (AWREADY) AWVALID <= 1'b0;
          if (WREADY) WVALID <= 1'b0;
          if ((!AWVALID || AWREADY) && (!WVALID || WREADY)) r_state <= DONE;
        end
        RD_REQ: begin
          if (ARVALID && ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
          end
          if (RREADY && RVALID) begin
            RREADY    <= 1'b0;
            r_miso_sr <= w_late ? 32'h0 : RDATA;
            if (w_late) ERR <= 1'b1;
            r_state   <= RD_SHIFT;
          end
        end
        RD_SHIFT: if (r_abort || w_cs_n || r_bit_cnt >= RD_END) r_state <= DONE;
        else if (w_sck_fall) begin
          SPI_MISO <= w_late ? r_miso_sr[31] : 1'b0;
          if (w_late) r_miso_sr <= {r_miso_sr[30:0], 1'b0};
        end
        DONE: if (w_cs_n) begin
          r_state <= IDLE;
          BUSY    <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_to_axi_master.sv
// tb_spi_to_axi_master: directed SPI frames against an AXI-Lite slave model with configurable ready/valid delays
module tb_spi_to_axi_master;
  localparam time HALF = 80ns;
  logic ACLK = 1'b0, ARESET = 1'b1;
  logic SPI_SCK = 1'b0, SPI_CS = 1'b1, SPI_MOSI = 1'b0, SPI_MISO;
  logic AWVALID, AWREADY, WVALID, WREADY, ARVALID, ARREADY, RVALID, RREADY, BUSY, ERR;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  int n_tests = 0, n_fail = 0;
  int aw_n = 0, w_n = 0, ar_n = 0, r_n = 0, aw_hi = 0, w_hi = 0, busy_bad = 0;
  int aw_wait = 0, w_wait = 0, r_wait = 0;
  int aw_dly = 0, w_dly = 0, r_dly = 3;
  logic r_pend = 1'b0;
  logic [31:0] aw_addr = '0, w_data = '0, ar_addr = '0, rdata = '0;
  logic [47:0] rx;
  int a0, w0, ar0, r0, ah0, wh0, bb0;

  spi_to_axi_master #(.BASE_ADDR(32'h4000_0000)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .SPI_SCK(SPI_SCK), .SPI_CS(SPI_CS), .SPI_MOSI(SPI_MOSI),
    .SPI_MISO(SPI_MISO), .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .ARADDR(ARADDR), .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .BUSY(BUSY), .ERR(ERR)
  );

  always #5ns ACLK = ~ACLK;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic spi_xfer(input int n, input logic [47:0] tx, output logic [47:0] rxd);
    rxd = '0;
    SPI_CS = 1'b0;
    #(HALF);
    for (int i = n - 1; i >= 0; i--) begin
      SPI_MOSI = tx[i];
      #(HALF);
      SPI_SCK = 1'b1;
      rxd = {rxd[46:0], SPI_MISO};
      #(HALF);
      SPI_SCK = 1'b0;
    end
    #(HALF);
    SPI_CS = 1'b1;
    SPI_MOSI = 1'b0;
    #(HALF * 2);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (BUSY && k < 3000) begin
      @(negedge ACLK);
      k++;
    end
    check(tag, BUSY, 1'b0);
  endtask

  task automatic snap();
    a0 = aw_n; w0 = w_n; ar0 = ar_n; r0 = r_n; ah0 = aw_hi; wh0 = w_hi; bb0 = busy_bad;
  endtask

  // AXI-Lite slave: handshakes sampled on posedge, READY/RVALID driven on negedge
  initial begin
    AWREADY = 1'b0; WREADY = 1'b0; ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0;
    forever begin
      @(posedge ACLK);
      if (AWVALID && AWREADY) begin aw_n++; aw_addr = AWADDR; end
      if (WVALID && WREADY) begin w_n++; w_data = WDATA; end
      if (ARVALID && ARREADY) begin ar_n++; ar_addr = ARADDR; r_pend = 1'b1; r_wait = 0; end
      if (RVALID && RREADY) begin r_n++; r_pend = 1'b0; end
      if (AWVALID) aw_hi++;
      if (WVALID) w_hi++;
      if ((AWVALID || WVALID || ARVALID || RREADY) && !BUSY) busy_bad++;
      @(negedge ACLK);
      aw_wait = AWVALID ? aw_wait + 1 : 0;
      w_wait  = WVALID ? w_wait + 1 : 0;
      AWREADY = AWVALID && aw_wait > aw_dly;
      WREADY  = WVALID && w_wait > w_dly;
      ARREADY = ARVALID;
      if (r_pend) r_wait++;
      RVALID = r_pend && r_wait > r_dly;
      RDATA  = RVALID ? rdata : 32'h0;
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #23ns;
    check("rst_ctrl", {AWVALID, WVALID, ARVALID, RREADY, SPI_MISO, BUSY, ERR}, 0);
    check("rst_awaddr", AWADDR, 0);
    check("rst_araddr", ARADDR, 0);
    check("rst_wdata", WDATA, 0);
    @(negedge ACLK);
    ARESET = 1'b0;
    repeat (5) @(negedge ACLK);

    snap();
    spi_xfer(40, {8'h05, 32'hA5A5_1234}, rx);
    wait_idle("wr1_idle");
    check("wr1_aw_n", aw_n - a0, 1);
    check("wr1_w_n", w_n - w0, 1);
    check("wr1_awaddr", aw_addr, 32'h4000_0014);
    check("wr1_wdata", w_data, 32'hA5A5_1234);
    check("wr1_err", ERR, 0);

    snap();
    rdata = 32'hDEAD_BEEF;
    spi_xfer(48, {8'h83, 40'h0}, rx);
    wait_idle("rd1_idle");
    check("rd1_ar_n", ar_n - ar0, 1);
    check("rd1_araddr", ar_addr, 32'h4000_000C);
    check("rd1_r_n", r_n - r0, 1);
    check("rd1_miso", rx, 48'h0000_DEAD_BEEF);
    check("rd1_err", ERR, 0);

    snap();
    w_dly = 9;
    spi_xfer(40, {8'h10, 32'h0BAD_F00D}, rx);
    wait_idle("wrd_idle");
    check("wrd_aw_cycles", aw_hi - ah0, 1);
    check("wrd_w_cycles", w_hi - wh0, 10);
    check("wrd_busy_held", busy_bad - bb0, 0);
    check("wrd_awaddr", aw_addr, 32'h4000_0040);
    check("wrd_wdata", w_data, 32'h0BAD_F00D);
    check("wrd_err", ERR, 0);
    w_dly = 0;

    snap();
    spi_xfer(20, {28'h0, 20'h215A5}, rx);
    wait_idle("abt_idle");
    check("abt_aw_valid", aw_hi - ah0, 0);
    check("abt_w_valid", w_hi - wh0, 0);
    check("abt_err", ERR, 1);
    spi_xfer(8, 48'h7F, rx);
    wait_idle("clr_idle");
    check("clr_err", ERR, 0);
    check("clr_no_axi", (aw_n - a0) + (w_n - w0) + (ar_n - ar0), 0);

    snap();
    r_dly = 200;
    rdata = 32'hCAFE_F00D;
    spi_xfer(48, {8'h84, 40'h0}, rx);
    wait_idle("late_idle");
    check("late_araddr", ar_addr, 32'h4000_0010);
    check("late_r_n", r_n - r0, 1);
    check("late_miso", rx, 48'h0);
    check("late_err", ERR, 1);
    r_dly = 3;
    spi_xfer(8, 48'h7F, rx);
    wait_idle("late_clr_idle");
    check("late_clr_err", ERR, 0);

    snap();
    aw_dly = 300;
    spi_xfer(40, {8'h01, 32'h1111_2222}, rx);
    wait_idle("to_idle");
    check("to_err", ERR, 1);
    check("to_aw_n", aw_n - a0, 1);
    check("to_w_n", w_n - w0, 1);
    aw_dly = 0;
    spi_xfer(8, 48'h7F, rx);
    wait_idle("to_clr_idle");
    check("to_clr_err", ERR, 0);

    aw_dly = 1000;
    w_dly = 1000;
    spi_xfer(40, {8'h02, 32'h5555_AAAA}, rx);
    check("rst_pre_valid", {AWVALID, WVALID, BUSY}, 3'b111);
    #3ns;
    ARESET = 1'b1;
    #1ns;
    check("rst_mid_ctrl", {AWVALID, WVALID, ARVALID, RREADY, SPI_MISO, BUSY, ERR}, 0);
    check("rst_mid_awaddr", AWADDR, 0);
    check("rst_mid_wdata", WDATA, 0);
    @(negedge ACLK);
    ARESET = 1'b0;
    aw_dly = 0;
    w_dly = 0;
    repeat (5) @(negedge ACLK);
    snap();
    spi_xfer(40, {8'h03, 32'h1357_9BDF}, rx);
    wait_idle("post_idle");
    check("post_aw_n", aw_n - a0, 1);
    check("post_w_n", w_n - w0, 1);
    check("post_awaddr", aw_addr, 32'h4000_000C);
    check("post_wdata", w_data, 32'h1357_9BDF);
    check("post_err", ERR, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
